alt_trigout_ts_fifo: RTL and testbench

//  Producer side of the alternate trigger-out timestamp path. Captures a White

---
 rtl/alt_trigout_ts_fifo.sv | 86 ++++++++
 tb/tb_alt_trigout_ts_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alt_trigout_ts_fifo.sv
// Trigger-out timestamp FIFO: captures {mask, TAI, cycles} per enabled trigger
// event and shows the oldest entry to the alt_trigout register bank.
module alt_trigout_ts_fifo #(
    parameter int g_depth_log2 = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [4:0]              trig_i,
    input  logic [4:0]              enable_i,
    input  logic [39:0]             tm_tai_i,
    input  logic [27:0]             tm_cycles_i,
    input  logic                    tm_valid_i,
    input  logic                    ts_cycles_rd_i,
    output logic                    ts_present_o,
    output logic [39:0]             ts_sec_o,
    output logic [27:0]             ts_cycles_o,
    output logic [4:0]              ts_mask_o,
    output logic [g_depth_log2:0]   level_o,
    output logic [15:0]             drop_cnt_o,
    input  logic                    drop_clr_i
);

    localparam int PW    = g_depth_log2;
    localparam int LW    = g_depth_log2 + 1;
    localparam int DEPTH = 1 << g_depth_log2;
    localparam int EW    = 5 + 40 + 28;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [4:0]    ev_mask;
    logic          ev, pop, push, drop, empty, full;
    logic [EW-1:0] head;

    assign ev_mask = trig_i & enable_i;
    assign ev      = |ev_mask;
    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = ts_cycles_rd_i && !empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign push    = ev && tm_valid_i && (!full || pop);
    assign drop    = ev && !push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        drop_cnt_d = drop_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (drop_clr_i)
            drop_cnt_d = '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {ev_mask, tm_tai_i, tm_cycles_i};
    end

    assign head         = empty ? '0 : mem_q[rd_ptr_q];
    assign ts_present_o = !empty;
    assign ts_mask_o    = head[EW-1 -: 5];
    assign ts_sec_o     = head[67:28];
    assign ts_cycles_o  = head[27:0];
    assign level_o      = level_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_alt_trigout_ts_fifo.sv
// Directed + randomized bench for alt_trigout_ts_fifo against a queue-based model.
module tb_alt_trigout_ts_fifo;

    localparam int G     = 4;
    localparam int DEPTH = 1 << G;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  trig, en;
    logic [39:0] tai;
    logic [27:0] cyc;
    logic        tmv, rd, clr;
    logic        present;
    logic [39:0] sec_o;
    logic [27:0] cyc_o;
    logic [4:0]  mask_o;
    logic [G:0]  level;
    logic [15:0] dcnt;

    int checks   = 0;
    int failures = 0;

    logic [72:0] mq[$];
    int          mdrop;

    alt_trigout_ts_fifo #(.g_depth_log2(G)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .trig_i(trig), .enable_i(en),
        .tm_tai_i(tai), .tm_cycles_i(cyc), .tm_valid_i(tmv),
        .ts_cycles_rd_i(rd), .ts_present_o(present), .ts_sec_o(sec_o),
        .ts_cycles_o(cyc_o), .ts_mask_o(mask_o), .level_o(level),
        .drop_cnt_o(dcnt), .drop_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [72:0] h;
        h = (mq.size() > 0) ? mq[0] : 73'd0;
        chk({tag, ".present"}, 64'(present), 64'(mq.size() > 0));
        chk({tag, ".level"},   64'(level),   64'(mq.size()));
        chk({tag, ".mask"},    64'(mask_o),  64'(h[72:68]));
        chk({tag, ".sec"},     64'(sec_o),   64'(h[67:28]));
        chk({tag, ".cycles"},  64'(cyc_o),   64'(h[27:0]));
        chk({tag, ".drop"},    64'(dcnt),    64'(mdrop));
    endtask

    // Model update from the specification's rules, then one clock edge.
    task automatic tick(input bit do_chk, input string tag);
        logic [4:0] m;
        bit popped;
        m = trig & en;
        popped = rd && mq.size() > 0;
        if (m != 0) begin
            if (tmv && (mq.size() < DEPTH || popped)) begin
                if (popped) void'(mq.pop_front());
                mq.push_back({m, tai, cyc});
                popped = 0;
            end else if (!clr && mdrop < 65535) mdrop++;
        end
        if (popped) void'(mq.pop_front());
        if (clr) mdrop = 0;
        @(posedge clk);
        #1;
        if (do_chk) check_model(tag);
    endtask

    task automatic idle_inputs();
        trig = 0; rd = 0; clr = 0; tmv = 1;
    endtask

    task automatic rand_ts();
        tai = {8'($urandom), 32'($urandom)};
        cyc = 28'($urandom);
    endtask

    initial begin
        rst_n = 0; en = 5'h1F; tai = 0; cyc = 0; mdrop = 0;
        idle_inputs();
        #12;
        check_model("reset");
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // First capture
        trig = 5'b00001; tai = 40'h12_3456_789A; cyc = 28'h0ABCDEF;
        tick(1, "cap1");
        chk("cap1.sec_const", 64'(sec_o), 64'h12_3456_789A);
        chk("cap1.cyc_const", 64'(cyc_o), 64'h0ABCDEF);
        chk("cap1.mask_const", 64'(mask_o), 64'h01);
        chk("cap1.level_const", 64'(level), 64'd1);
        idle_inputs(); rd = 1;
        tick(1, "pop1");

        // Masked coalescing
        idle_inputs(); trig = 5'b10110; en = 5'b10010; rand_ts();
        tick(1, "coal");
        chk("coal.mask_const", 64'(mask_o), 64'h12);
        trig = 5'b00001;
        tick(1, "disabled");
        chk("disabled.level_const", 64'(level), 64'd1);
        idle_inputs(); en = 5'h1F; rd = 1;
        tick(1, "pop2");

        // Overfill with 17 events
        idle_inputs();
        for (int i = 0; i < 17; i++) begin
            trig = 5'($urandom_range(1, 31)); rand_ts();
            tick(1, "fill");
        end
        chk("full.level_const", 64'(level), 64'd16);
        chk("full.drop_const", 64'(dcnt), 64'd1);

        // Full: push + pop same cycle
        trig = 5'b00100; rd = 1; rand_ts();
        tick(1, "fullpp");
        chk("fullpp.level_const", 64'(level), 64'd16);
        chk("fullpp.drop_const", 64'(dcnt), 64'd1);

        // Drain in order
        idle_inputs(); rd = 1;
        for (int i = 0; i < 16; i++) tick(1, "drain");
        chk("drain.present_const", 64'(present), 64'd0);
        tick(1, "pop_empty");

        // Empty: push + pop same cycle, then invalid-time drop
        trig = 5'b01000; rand_ts();
        tick(1, "emptypp");
        chk("emptypp.level_const", 64'(level), 64'd1);
        idle_inputs(); trig = 5'b00010; tmv = 0;
        tick(1, "tmv0");
        chk("tmv0.drop_const", 64'(dcnt), 64'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            trig = ($urandom_range(0, 2) != 0) ? 5'($urandom) : 5'd0;
            en   = 5'($urandom);
            tmv  = ($urandom_range(0, 7) != 0);
            rd   = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 40) == 0);
            rand_ts();
            tick(1, "rand");
        end

        // Saturate the drop counter
        idle_inputs(); en = 5'h1F; trig = 5'b00001; tmv = 0;
        while (mdrop < 65535) tick(0, "sat");
        check_model("sat");
        tick(1, "sat_hold");
        chk("sat.hold_const", 64'(dcnt), 64'hFFFF);
        idle_inputs(); clr = 1;
        tick(1, "clr");
        chk("clr.const", 64'(dcnt), 64'd0);

        // Asynchronous reset mid-burst
        idle_inputs(); rd = 1;
        while (mq.size() > 0) tick(0, "flush");
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            trig = 5'($urandom_range(1, 31)); rand_ts();
            tick(1, "burst");
        end
        chk("burst.level_const", 64'(level), 64'd5);
        #2 rst_n = 0;
        mq.delete(); mdrop = 0;
        #1;
        chk("arst.level", 64'(level), 64'd0);
        chk("arst.present", 64'(present), 64'd0);
        check_model("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
